modulo_leitor_display_multiplexado: RTL and testbench

Receiver for the multiplexed 4-digit 7-segment bus the bottling controller drives. It samples the active-low anode lines (Nac_7segmentos) and segment lines (Nout_7seg), decodes each scanned digit back to BCD and assembles complete frames. It publishes the bottle-dozens count and the secondary cork-buffer count as binary once a frame is stable. It sits beside the controller on clk_div as an on-chip self-check and readback path, and also serves as the bench monitor.

---
 rtl/modulo_leitor_display_multiplexado_pkg.sv | 34 +++
 rtl/modulo_leitor_display_multiplexado_if.sv | 24 ++
 rtl/modulo_decodificador_7seg_bcd.sv | 26 ++
 rtl/modulo_leitor_display_multiplexado.sv | 198 +++++++++++++++++++
 tb/tb_modulo_leitor_display_multiplexado.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/modulo_leitor_display_multiplexado_pkg.sv
// Shared constants for the 7-segment bus readback: segment patterns, digit slots, FSM encoding.
// Segment patterns are active-high ABCDEFG (bit 6 = A, bit 0 = G).
package modulo_leitor_display_multiplexado_pkg;

    localparam logic [6:0] SEG_0 = 7'b1111110;
    localparam logic [6:0] SEG_1 = 7'b0110000;
    localparam logic [6:0] SEG_2 = 7'b1101101;
    localparam logic [6:0] SEG_3 = 7'b1111001;
    localparam logic [6:0] SEG_4 = 7'b0110011;
    localparam logic [6:0] SEG_5 = 7'b1011011;
    localparam logic [6:0] SEG_6 = 7'b1011111;
    localparam logic [6:0] SEG_7 = 7'b1110000;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1111011;

    // Anode bit k carries digit slot k of the frame {d3,d2,d1,d0}
    localparam logic [1:0] SLOT_GAR_DEZ = 2'd0;
    localparam logic [1:0] SLOT_GAR_UNI = 2'd1;
    localparam logic [1:0] SLOT_ROL_DEZ = 2'd2;
    localparam logic [1:0] SLOT_ROL_UNI = 2'd3;

    typedef enum logic [1:0] {
        ST_SYNC    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_CHECK   = 2'd2
    } estado_t;

    function automatic logic [6:0] bcd_para_bin(input logic [3:0] dez, input logic [3:0] uni);
        logic [6:0] d7;
        d7 = {3'b000, dez};
        return (d7 << 3) + (d7 << 1) + {3'b000, uni};
    endfunction

endpackage

// File: rtl/modulo_leitor_display_multiplexado_if.sv
// Display bus (driven by the controller) plus the decoded readback results.
interface modulo_leitor_display_multiplexado_if;
    logic [3:0]  Nac_7segmentos;
    logic [7:0]  Nout_7seg;
    logic [6:0]  garrafas_bin;
    logic [6:0]  rolhas_bin;
    logic [15:0] digitos_bcd;
    logic        dado_valido;
    logic        err_segmento;
    logic        err_multi_anodo;
    logic        scan_parado;

    modport master (
        output Nac_7segmentos, Nout_7seg,
        input  garrafas_bin, rolhas_bin, digitos_bcd, dado_valido,
        input  err_segmento, err_multi_anodo, scan_parado
    );

    modport slave (
        input  Nac_7segmentos, Nout_7seg,
        output garrafas_bin, rolhas_bin, digitos_bcd, dado_valido,
        output err_segmento, err_multi_anodo, scan_parado
    );
endinterface

// File: rtl/modulo_decodificador_7seg_bcd.sv
// Combinational 7-segment (active-high ABCDEFG) to BCD decoder; valido_o low for any non-digit pattern.
module modulo_decodificador_7seg_bcd
    import modulo_leitor_display_multiplexado_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] bcd_o,
    output logic       valido_o
);
    always_comb begin
        bcd_o    = 4'd0;
        valido_o = 1'b1;
        case (seg_i)
            SEG_0:   bcd_o = 4'd0;
            SEG_1:   bcd_o = 4'd1;
            SEG_2:   bcd_o = 4'd2;
            SEG_3:   bcd_o = 4'd3;
            SEG_4:   bcd_o = 4'd4;
            SEG_5:   bcd_o = 4'd5;
            SEG_6:   bcd_o = 4'd6;
            SEG_7:   bcd_o = 4'd7;
            SEG_8:   bcd_o = 4'd8;
            SEG_9:   bcd_o = 4'd9;
            default: valido_o = 1'b0;
        endcase
    end
endmodule

// File: rtl/modulo_leitor_display_multiplexado.sv
// Samples the multiplexed 4-digit display bus, rebuilds frames and publishes the two
// counts once FRAMES_MATCH identical frames have been seen.
module modulo_leitor_display_multiplexado
    import modulo_leitor_display_multiplexado_pkg::*;
#(
    parameter int FRAMES_MATCH = 2,
    parameter int TIMEOUT      = 16
) (
    input  logic clk,
    input  logic reset,
    modulo_leitor_display_multiplexado_if.slave bus
);
    localparam logic [2:0] MATCH_MAX = 3'(FRAMES_MATCH);
    localparam logic [7:0] TO_MAX    = 8'(TIMEOUT);

    logic [3:0]  nac_q, nac_d;
    logic [6:0]  nseg_q, nseg_d;
    logic [3:0]  an_prev_q, an_prev_d;
    logic [7:0]  to_cnt_q, to_cnt_d;
    estado_t     estado_q, estado_d;
    logic [3:0]  seen_q, seen_d;
    logic [15:0] frame_q, frame_d;
    logic [15:0] prev_q, prev_d;
    logic [15:0] digitos_q, digitos_d;
    logic [2:0]  match_q, match_d;
    logic        publicado_q, publicado_d;
    logic [6:0]  garrafas_q, garrafas_d;
    logic [6:0]  rolhas_q, rolhas_d;
    logic        dado_valido_q, dado_valido_d;
    logic        err_seg_q, err_seg_d;
    logic        err_multi_q, err_multi_d;
    logic        scan_parado_q, scan_parado_d;

    logic [3:0] an;
    logic [6:0] seg;
    logic [3:0] dig_bcd;
    logic       dig_ok, one_hot, multi, seg_bad, dig_cap, captura_d0, stall;
    logic [1:0] slot;

    // DP (Nout_7seg[0]) carries no digit information, so it is not sampled
    assign nac_d  = bus.Nac_7segmentos;
    assign nseg_d = bus.Nout_7seg[7:1];
    assign an     = ~nac_q;
    assign seg    = ~nseg_q;

    modulo_decodificador_7seg_bcd u_dec (
        .seg_i    (seg),
        .bcd_o    (dig_bcd),
        .valido_o (dig_ok)
    );

    always_comb begin
        one_hot = 1'b1;
        slot    = SLOT_GAR_DEZ;
        case (an)
            4'b0001: slot = SLOT_GAR_DEZ;
            4'b0010: slot = SLOT_GAR_UNI;
            4'b0100: slot = SLOT_ROL_DEZ;
            4'b1000: slot = SLOT_ROL_UNI;
            default: one_hot = 1'b0;
        endcase
    end

    // A blank digit with a single anode is neither captured nor flagged
    assign multi      = (an != 4'b0000) && !one_hot;
    assign seg_bad    = one_hot && !dig_ok && (seg != 7'd0);
    assign dig_cap    = one_hot && dig_ok;
    assign captura_d0 = dig_cap && (slot == SLOT_GAR_DEZ);

    // Counts cycles the anode lines have held their current value
    assign an_prev_d = an;
    assign to_cnt_d  = (an != an_prev_q) ? 8'd1 :
                       (to_cnt_q == TO_MAX) ? TO_MAX : to_cnt_q + 8'd1;
    assign stall     = (to_cnt_d == TO_MAX);

    always_comb begin
        estado_d      = estado_q;
        seen_d        = seen_q;
        frame_d       = frame_q;
        prev_d        = prev_q;
        digitos_d     = digitos_q;
        match_d       = match_q;
        publicado_d   = publicado_q;
        garrafas_d    = garrafas_q;
        rolhas_d      = rolhas_q;
        dado_valido_d = 1'b0;
        err_seg_d     = err_seg_q | seg_bad;
        err_multi_d   = err_multi_q | multi;
        scan_parado_d = scan_parado_q;

        case (estado_q)
            ST_SYNC: begin
                if (captura_d0) begin
                    frame_d[{SLOT_GAR_DEZ, 2'b00} +: 4] = dig_bcd;
                    seen_d        = 4'b0001;
                    estado_d      = ST_COLLECT;
                    scan_parado_d = 1'b0;
                end
            end
            ST_COLLECT: begin
                if (multi || seg_bad) begin
                    estado_d = ST_SYNC;
                    seen_d   = 4'b0000;
                    match_d  = 3'd0;
                end else if (captura_d0) begin
                    frame_d[{SLOT_GAR_DEZ, 2'b00} +: 4] = dig_bcd;
                    seen_d = 4'b0001;
                end else if (dig_cap && (seen_q != 4'b0000)) begin
                    frame_d[{slot, 2'b00} +: 4] = dig_bcd;
                    seen_d = seen_q | (4'b0001 << slot);
                    if (seen_d == 4'b1111) estado_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (frame_q == prev_q) begin
                    match_d = (match_q >= MATCH_MAX) ? MATCH_MAX : match_q + 3'd1;
                end else begin
                    match_d = 3'd1;
                    prev_d  = frame_q;
                end
                if ((match_d == MATCH_MAX) && ((frame_q != digitos_q) || !publicado_q)) begin
                    digitos_d     = frame_q;
                    garrafas_d    = bcd_para_bin(frame_q[{SLOT_GAR_DEZ, 2'b00} +: 4],
                                                 frame_q[{SLOT_GAR_UNI, 2'b00} +: 4]);
                    rolhas_d      = bcd_para_bin(frame_q[{SLOT_ROL_DEZ, 2'b00} +: 4],
                                                 frame_q[{SLOT_ROL_UNI, 2'b00} +: 4]);
                    dado_valido_d = 1'b1;
                    publicado_d   = 1'b1;
                end
                // The next frame's first digit arrives during this cycle on a continuous scan
                estado_d = ST_COLLECT;
                seen_d   = 4'b0000;
                if (multi || seg_bad) begin
                    estado_d = ST_SYNC;
                    match_d  = 3'd0;
                end else if (captura_d0) begin
                    frame_d[{SLOT_GAR_DEZ, 2'b00} +: 4] = dig_bcd;
                    seen_d = 4'b0001;
                end
            end
            default: estado_d = ST_SYNC;
        endcase

        if (stall) begin
            scan_parado_d = 1'b1;
            estado_d      = ST_SYNC;
            seen_d        = 4'b0000;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            nac_q         <= 4'hF;
            nseg_q        <= 7'h7F;
            an_prev_q     <= 4'h0;
            to_cnt_q      <= 8'd0;
            estado_q      <= ST_SYNC;
            seen_q        <= 4'h0;
            frame_q       <= 16'h0;
            prev_q        <= 16'h0;
            digitos_q     <= 16'h0;
            match_q       <= 3'd0;
            publicado_q   <= 1'b0;
            garrafas_q    <= 7'd0;
            rolhas_q      <= 7'd0;
            dado_valido_q <= 1'b0;
            err_seg_q     <= 1'b0;
            err_multi_q   <= 1'b0;
            scan_parado_q <= 1'b0;
        end else begin
            nac_q         <= nac_d;
            nseg_q        <= nseg_d;
            an_prev_q     <= an_prev_d;
            to_cnt_q      <= to_cnt_d;
            estado_q      <= estado_d;
            seen_q        <= seen_d;
            frame_q       <= frame_d;
            prev_q        <= prev_d;
            digitos_q     <= digitos_d;
            match_q       <= match_d;
            publicado_q   <= publicado_d;
            garrafas_q    <= garrafas_d;
            rolhas_q      <= rolhas_d;
            dado_valido_q <= dado_valido_d;
            err_seg_q     <= err_seg_d;
            err_multi_q   <= err_multi_d;
            scan_parado_q <= scan_parado_d;
        end
    end

    assign bus.garrafas_bin    = garrafas_q;
    assign bus.rolhas_bin      = rolhas_q;
    assign bus.digitos_bcd     = digitos_q;
    assign bus.dado_valido     = dado_valido_q;
    assign bus.err_segmento    = err_seg_q;
    assign bus.err_multi_anodo = err_multi_q;
    assign bus.scan_parado     = scan_parado_q;
endmodule

// File: tb/tb_modulo_leitor_display_multiplexado.sv
// Directed bench for the display readback: scans hand-built frames and checks published values.
module tb_modulo_leitor_display_multiplexado;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    modulo_leitor_display_multiplexado_if bus_if ();

    modulo_leitor_display_multiplexado #(
        .FRAMES_MATCH (2),
        .TIMEOUT      (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    logic [6:0] ref_seg;
    logic [3:0] ref_bcd;
    logic       ref_ok;
    logic [7:0] nv;

    modulo_decodificador_7seg_bcd u_ref (
        .seg_i    (ref_seg),
        .bcd_o    (ref_bcd),
        .valido_o (ref_ok)
    );

    localparam logic [3:0] AN_IDLE = 4'b1111;
    localparam logic [3:0] AN0     = 4'b1110;
    localparam logic [3:0] AN1     = 4'b1101;
    localparam logic [3:0] AN2     = 4'b1011;
    localparam logic [3:0] AN3     = 4'b0111;

    int n_checks   = 0;
    int n_fail     = 0;
    int pulse_cnt  = 0;
    int pulse_base = 0;

    always @(negedge clk) begin
        if (bus_if.dado_valido === 1'b1) pulse_cnt <= pulse_cnt + 1;
    end

    // Active-low Nout codes, DP off
    function automatic logic [7:0] nout_de(input int d);
        case (d)
            0: return 8'h03;
            1: return 8'h9F;
            2: return 8'h25;
            3: return 8'h0D;
            4: return 8'h99;
            5: return 8'h49;
            6: return 8'h41;
            7: return 8'h1F;
            8: return 8'h01;
            9: return 8'h09;
            default: return 8'hFF;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_pulsos(input string tag, input int exp);
        chk(tag, 32'(pulse_cnt - pulse_base), 32'(exp));
        pulse_base = pulse_cnt;
    endtask

    task automatic put(input logic [3:0] nac, input logic [7:0] nout);
        @(negedge clk);
        bus_if.Nac_7segmentos = nac;
        bus_if.Nout_7seg      = nout;
    endtask

    task automatic frame(input int d0, input int d1, input int d2, input int d3);
        put(AN0, nout_de(d0));
        put(AN1, nout_de(d1));
        put(AN2, nout_de(d2));
        put(AN3, nout_de(d3));
        $display("frame d0..d3 = %0d %0d %0d %0d", d0, d1, d2, d3);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) put(AN_IDLE, 8'hFF);
    endtask

    task automatic passo_chk(input string tag, input logic exp);
        @(negedge clk);
        chk(tag, 32'(bus_if.dado_valido), 32'(exp));
        bus_if.Nac_7segmentos = AN_IDLE;
        bus_if.Nout_7seg      = 8'hFF;
    endtask

    task automatic chk_tudo_zero(input string tag);
        chk({tag, "_gar"}, 32'(bus_if.garrafas_bin), 32'd0);
        chk({tag, "_rol"}, 32'(bus_if.rolhas_bin), 32'd0);
        chk({tag, "_dig"}, 32'(bus_if.digitos_bcd), 32'd0);
        chk({tag, "_dv"}, 32'(bus_if.dado_valido), 32'd0);
        chk({tag, "_eseg"}, 32'(bus_if.err_segmento), 32'd0);
        chk({tag, "_emul"}, 32'(bus_if.err_multi_anodo), 32'd0);
        chk({tag, "_stall"}, 32'(bus_if.scan_parado), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus_if.Nac_7segmentos = AN_IDLE;
        bus_if.Nout_7seg      = 8'hFF;
        repeat (3) @(negedge clk);
        chk_tudo_zero("reset");

        // Decoder table, then one non-digit (only G lit)
        for (int d = 0; d < 10; d++) begin
            nv = nout_de(d);
            ref_seg = ~nv[7:1];
            #1;
            chk("dec_bcd", 32'(ref_bcd), 32'(d));
            chk("dec_ok", 32'(ref_ok), 32'd1);
        end
        nv = 8'hFD;
        ref_seg = ~nv[7:1];
        #1;
        chk("dec_bad_ok", 32'(ref_ok), 32'd0);

        @(negedge clk);
        reset = 1'b0;

        // Valid digits 0,2,4,7: first frame only primes the match counter
        frame(0, 2, 4, 7);
        idle(5);
        chk_pulsos("a_frame1_pulses", 0);
        frame(0, 2, 4, 7);
        passo_chk("a_lat_n1", 1'b0);
        passo_chk("a_lat_n2", 1'b0);
        passo_chk("a_lat_n3", 1'b1);
        passo_chk("a_lat_n4", 1'b0);
        idle(1);
        chk_pulsos("a_frame2_pulses", 1);
        chk("a_gar", 32'(bus_if.garrafas_bin), 32'd2);
        chk("a_rol", 32'(bus_if.rolhas_bin), 32'd47);
        chk("a_dig", 32'(bus_if.digitos_bcd), 32'h7420);
        frame(0, 2, 4, 7);
        frame(0, 2, 4, 7);
        idle(5);
        chk_pulsos("a_unchanged_pulses", 0);

        // Change after publish
        frame(0, 2, 5, 7);
        idle(5);
        chk_pulsos("b_first_new_pulses", 0);
        chk("b_rol_hold", 32'(bus_if.rolhas_bin), 32'd47);
        frame(0, 2, 5, 7);
        idle(5);
        chk_pulsos("b_second_new_pulses", 1);
        chk("b_rol", 32'(bus_if.rolhas_bin), 32'd57);
        chk("b_dig", 32'(bus_if.digitos_bcd), 32'h7520);

        // Bad segment pattern on slot1
        chk("c_eseg_before", 32'(bus_if.err_segmento), 32'd0);
        put(AN0, nout_de(0));
        put(AN1, 8'hFD);
        put(AN2, nout_de(5));
        put(AN3, nout_de(7));
        $display("frame with undecodable slot1");
        idle(5);
        chk("c_eseg", 32'(bus_if.err_segmento), 32'd1);
        chk_pulsos("c_bad_pulses", 0);
        frame(0, 2, 5, 7);
        frame(0, 2, 5, 7);
        idle(5);
        chk("c_eseg_sticky", 32'(bus_if.err_segmento), 32'd1);
        chk_pulsos("c_same_pulses", 0);
        chk("c_rol_hold", 32'(bus_if.rolhas_bin), 32'd57);
        frame(0, 2, 4, 7);
        idle(5);
        chk_pulsos("c_recov1_pulses", 0);
        frame(0, 2, 4, 7);
        idle(5);
        chk_pulsos("c_recov2_pulses", 1);
        chk("c_dig", 32'(bus_if.digitos_bcd), 32'h7420);

        // Two anodes at once mid-frame: the partial frame must not complete
        chk("d_emul_before", 32'(bus_if.err_multi_anodo), 32'd0);
        put(AN0, nout_de(0));
        put(AN1, nout_de(5));
        put(4'b1100, nout_de(0));
        put(AN2, nout_de(4));
        put(AN3, nout_de(7));
        $display("frame with two anodes active");
        idle(5);
        chk("d_emul", 32'(bus_if.err_multi_anodo), 32'd1);
        frame(0, 5, 4, 7);
        idle(5);
        chk_pulsos("d_after_multi_pulses", 0);
        frame(0, 5, 4, 7);
        idle(5);
        chk_pulsos("d_second_pulses", 1);
        chk("d_gar", 32'(bus_if.garrafas_bin), 32'd5);
        chk("d_dig", 32'(bus_if.digitos_bcd), 32'h7450);

        // Stalled scan
        idle(5);
        chk("e_stall_short", 32'(bus_if.scan_parado), 32'd0);
        idle(15);
        chk("e_stall", 32'(bus_if.scan_parado), 32'd1);
        frame(0, 5, 4, 7);
        idle(3);
        chk("e_stall_clear", 32'(bus_if.scan_parado), 32'd0);
        chk_pulsos("e_pulses", 0);

        // Reset during slot2
        put(AN0, nout_de(0));
        put(AN1, nout_de(2));
        @(negedge clk);
        bus_if.Nac_7segmentos = AN2;
        bus_if.Nout_7seg      = nout_de(4);
        reset = 1'b1;
        @(negedge clk);
        chk_tudo_zero("f_reset");
        reset = 1'b0;
        bus_if.Nac_7segmentos = AN_IDLE;
        bus_if.Nout_7seg      = 8'hFF;
        pulse_base = pulse_cnt;
        frame(0, 2, 4, 7);
        idle(5);
        chk_pulsos("f_frame1_pulses", 0);
        frame(0, 2, 4, 7);
        idle(5);
        chk_pulsos("f_frame2_pulses", 1);
        chk("f_gar", 32'(bus_if.garrafas_bin), 32'd2);
        chk("f_rol", 32'(bus_if.rolhas_bin), 32'd47);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
